// File: rtl/midi_chan_event_decoder.sv
// Multi-channel MIDI channel-voice decoder with running status, event FIFO and per-channel pitch-bend registers.
// Define MIDICTL_REALTIME_EN to emit F8/FA/FB/FC real-time bytes as type-7 events.
module midi_chan_event_decoder #(
    parameter int NCH        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset_reg_N,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic [3:0]        base_ch,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_type,
    output logic [3:0]        evt_ch,
    output logic [6:0]        evt_num,
    output logic [13:0]       evt_val,
    output logic [NCH*14-1:0] pitch_bend,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    input  logic              ovf_clr
);

    typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} state_t;

    localparam logic [4:0] NCH_W = 5'(NCH);

    state_t      state, state_nxt;
    logic        rs_vld;
    logic [3:0]  rs_op;
    logic [3:0]  rs_ch;
    logic [6:0]  d1;

    logic        is_chst, is_sys, is_data, two_byte;
    logic        in_first;
    logic        take_d1, msg_done, accept, push, pb_we;
    logic [3:0]  rel;
    logic [2:0]  w_type;
    logic [3:0]  w_ch;
    logic [6:0]  w_num;
    logic [13:0] w_val;

    assign is_chst  = byte_valid & byte_data[7] & (byte_data[7:4] != 4'hF);
    assign is_sys   = byte_valid & (byte_data[7:3] == 5'b11110);
    assign is_data  = byte_valid & ~byte_data[7];
    assign two_byte = (rs_op != 4'hC) && (rs_op != 4'hD);
    assign in_first = (state == DATA1) || ((state == IDLE) && rs_vld);
    assign rel      = rs_ch - base_ch;
    assign accept   = ({1'b0, rel} < NCH_W);

    // Parser state register
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) state <= IDLE;
        else              state <= state_nxt;
    end

    // Real-time bytes fall through every branch, so they never disturb the parser
    always_comb begin
        state_nxt = state;
        if (is_chst)
            state_nxt = DATA1;
        else if (is_sys)
            state_nxt = SKIP;
        else if (is_data) begin
            case (state)
                IDLE:    if (rs_vld) state_nxt = two_byte ? DATA2 : DATA1;
                DATA1:   state_nxt = two_byte ? DATA2 : DATA1;
                DATA2:   state_nxt = DATA1;
                default: state_nxt = SKIP;
            endcase
        end
    end

    always_comb begin
        take_d1  = is_data & in_first & two_byte;
        msg_done = is_data & ((state == DATA2) | (in_first & ~two_byte));
        push     = 1'b0;
        pb_we    = 1'b0;
        w_type   = 3'd0;
        w_ch     = rs_ch;
        w_num    = 7'd0;
        w_val    = 14'd0;
        case (rs_op)
            4'h8: begin w_type = 3'd0; w_num = d1; w_val = {7'd0, byte_data[6:0]}; end
            4'h9: begin
                w_type = (byte_data[6:0] == 7'd0) ? 3'd0 : 3'd1;
                w_num  = d1;
                w_val  = {7'd0, byte_data[6:0]};
            end
            4'hA: begin w_type = 3'd2; w_num = d1; w_val = {7'd0, byte_data[6:0]}; end
            4'hB: begin w_type = 3'd3; w_num = d1; w_val = {7'd0, byte_data[6:0]}; end
            4'hC: begin w_type = 3'd4; w_num = byte_data[6:0]; end
            4'hD: begin w_type = 3'd5; w_num = byte_data[6:0]; end
            4'hE: begin w_type = 3'd6; w_val = {byte_data[6:0], d1}; end
            default: w_type = 3'd0;
        endcase
        if (msg_done && accept) begin
            push  = 1'b1;
            pb_we = (rs_op == 4'hE);
        end
`ifdef MIDICTL_REALTIME_EN
        if (byte_valid && (byte_data == 8'hF8 || byte_data == 8'hFA ||
                           byte_data == 8'hFB || byte_data == 8'hFC)) begin
            push   = 1'b1;
            w_type = 3'd7;
            w_ch   = 4'd0;
            w_num  = byte_data[6:0];
            w_val  = 14'd0;
        end
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rs_vld <= 1'b0;
            rs_op  <= 4'h0;
            rs_ch  <= 4'h0;
        end else if (is_chst) begin
            rs_vld <= 1'b1;
            rs_op  <= byte_data[7:4];
            rs_ch  <= byte_data[3:0];
        end else if (is_sys) begin
            rs_vld <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (take_d1) d1 <= byte_data[6:0];
    end

    // Pitch-bend slots indexed by window offset, centred at reset
    logic [13:0] pb [NCH];

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < NCH; i++) pb[i] <= 14'h2000;
        end else if (pb_we) begin
            for (int i = 0; i < NCH; i++)
                if ({1'b0, rel} == 5'(i)) pb[i] <= w_val;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pb
        assign pitch_bend[g*14 +: 14] = pb[g];
    end

    // Event FIFO: extra pointer bit distinguishes full from empty
    logic [27:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, wr_en, drop;
    logic [27:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & evt_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {w_type, w_ch, w_num, w_val};
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign evt_valid  = ~empty;
    assign evt_type   = evt_valid ? head[27:25] : 3'd0;
    assign evt_ch     = evt_valid ? head[24:21] : 4'd0;
    assign evt_num    = evt_valid ? head[20:14] : 7'd0;
    assign evt_val    = evt_valid ? head[13:0]  : 14'd0;
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_midi_chan_event_decoder.sv
// Scoreboard bench for midi_chan_event_decoder (NCH 4, FIFO_DEPTH 4); honours MIDICTL_REALTIME_EN.
module tb_midi_chan_event_decoder;

    logic        CLOCK_50 = 1'b0;
    logic        reset_reg_N = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [3:0]  base_ch = 4'h0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_type;
    logic [3:0]  evt_ch;
    logic [6:0]  evt_num;
    logic [13:0] evt_val;
    logic [55:0] pitch_bend;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int passes = 0;
    logic [31:0] sb [$];

    midi_chan_event_decoder #(.NCH(4), .FIFO_DEPTH(4), .AW(2)) dut (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N),
        .byte_valid(byte_valid), .byte_data(byte_data), .base_ch(base_ch),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_ch(evt_ch), .evt_num(evt_num), .evt_val(evt_val),
        .pitch_bend(pitch_bend), .fifo_level(fifo_level),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic expect_evt(input logic [2:0] t, input logic [3:0] c,
                              input logic [6:0] n, input logic [13:0] v);
        sb.push_back({4'd0, t, c, n, v});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk_pb(input logic [13:0] e0, input logic [13:0] e1,
                          input logic [13:0] e2, input logic [13:0] e3);
        chk("pb0", {18'd0, pitch_bend[13:0]},  {18'd0, e0});
        chk("pb1", {18'd0, pitch_bend[27:14]}, {18'd0, e1});
        chk("pb2", {18'd0, pitch_bend[41:28]}, {18'd0, e2});
        chk("pb3", {18'd0, pitch_bend[55:42]}, {18'd0, e3});
    endtask

    // Monitor: every accepted head is compared against the oldest expectation
    always @(negedge CLOCK_50) begin
        if (reset_reg_N && evt_valid && evt_ready) begin
            if (sb.size() == 0)
                chk("evt_unexpected", {4'd0, evt_type, evt_ch, evt_num, evt_val}, 32'hFFFF_FFFF);
            else
                chk("evt", {4'd0, evt_type, evt_ch, evt_num, evt_val}, sb.pop_front());
        end
    end

    initial begin
        idle(3);
        reset_reg_N = 1'b1;
        idle(1);
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_fields", {4'd0, evt_type, evt_ch, evt_num, evt_val}, 32'd0);
        chk_pb(14'h2000, 14'h2000, 14'h2000, 14'h2000);

        // Note-on, then running-status note-on with velocity 0
        evt_ready = 1'b1;
        send(8'h90);
        send(8'h3C);
        chk("lat_mid", {31'd0, evt_valid}, 32'd0);
        expect_evt(3'd1, 4'd0, 7'h3C, 14'h0064);
        send(8'h64);
        chk("lat_on", {31'd0, evt_valid}, 32'd1);
        send(8'h3E);
        expect_evt(3'd0, 4'd0, 7'h3E, 14'h0000);
        send(8'h00);
        chk("lat_off", {31'd0, evt_valid}, 32'd1);
        idle(2);

        // Pitch bend with a wrapped window
        base_ch = 4'hE;
        send(8'hE1); send(8'h00);
        expect_evt(3'd6, 4'd1, 7'h00, 14'h2000);
        send(8'h40);
        idle(1);
        chk_pb(14'h2000, 14'h2000, 14'h2000, 14'h2000);
        send(8'h7F);
        expect_evt(3'd6, 4'd1, 7'h00, 14'h00FF);
        send(8'h01);
        idle(1);
        chk_pb(14'h2000, 14'h2000, 14'h2000, 14'h00FF);
        send(8'hE4); send(8'h7F); send(8'h7F);
        idle(2);
        chk("filt_none", {31'd0, evt_valid}, 32'd0);
        chk_pb(14'h2000, 14'h2000, 14'h2000, 14'h00FF);
        send(8'h90); send(8'h10);
        expect_evt(3'd1, 4'd0, 7'h10, 14'h0020);
        send(8'h20);
        idle(2);

        // Real-time byte inside a message, other message types, DATA2 abort
        base_ch = 4'h0;
        send(8'hB0); send(8'h07);
`ifdef MIDICTL_REALTIME_EN
        expect_evt(3'd7, 4'd0, 7'h78, 14'h0000);
`endif
        send(8'hF8);
        expect_evt(3'd3, 4'd0, 7'h07, 14'h0050);
        send(8'h50);
        send(8'h08); send(8'hFE);
        expect_evt(3'd3, 4'd0, 7'h08, 14'h0051);
        send(8'h51);
        send(8'hA0); send(8'h40);
        expect_evt(3'd2, 4'd0, 7'h40, 14'h0011);
        send(8'h11);
        send(8'hD0);
        expect_evt(3'd5, 4'd0, 7'h22, 14'h0000);
        send(8'h22);
        expect_evt(3'd5, 4'd0, 7'h33, 14'h0000);
        send(8'h33);
        send(8'h80); send(8'h45);
        expect_evt(3'd0, 4'd0, 7'h45, 14'h0012);
        send(8'h12);
        send(8'h90); send(8'h3C);
        send(8'hB0); send(8'h07);
        expect_evt(3'd3, 4'd0, 7'h07, 14'h0010);
        send(8'h10);
        idle(3);
        chk("sb_drain1", sb.size(), 32'd0);

        // Overflow with the consumer stalled
        evt_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send(8'hC0);
            if (i <= 4) expect_evt(3'd4, 4'd0, 7'(i), 14'h0000);
            send(8'(i));
        end
        idle(2);
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ovf", {31'd0, overflow}, 32'd1);
        chk("full_head", {25'd0, evt_num}, 32'd1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // New drop and clear in the same cycle: set wins
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b1; byte_data = 8'h07; ovf_clr = 1'b1;
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("ovf_clr2", {31'd0, overflow}, 32'd0);

        // Push and pop together while full
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b1; byte_data = 8'h08; evt_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        byte_valid = 1'b0; evt_ready = 1'b0;
        expect_evt(3'd4, 4'd0, 7'h08, 14'h0000);
        chk("pp_level", {29'd0, fifo_level}, 32'd4);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        chk("pp_head", {25'd0, evt_num}, 32'd2);
        evt_ready = 1'b1;
        idle(8);
        chk("sb_drain2", sb.size(), 32'd0);
        chk("empty_level", {29'd0, fifo_level}, 32'd0);

        // SysEx is skipped and clears running status
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h05);
        idle(2);
        chk("sysex_none", {31'd0, evt_valid}, 32'd0);

        // Reset mid-message flushes the FIFO and the pitch-bend slots
        evt_ready = 1'b0;
        send(8'hC0); send(8'h09);
        chk("pre_rst_level", {29'd0, fifo_level}, 32'd1);
        send(8'h90); send(8'h3C);
        reset_reg_N = 1'b0;
        idle(2);
        chk("rst2_level", {29'd0, fifo_level}, 32'd0);
        chk("rst2_valid", {31'd0, evt_valid}, 32'd0);
        chk_pb(14'h2000, 14'h2000, 14'h2000, 14'h2000);
        reset_reg_N = 1'b1;
        evt_ready = 1'b1;
        send(8'h3C); send(8'h40);
        idle(3);
        chk("post_rst_none", {31'd0, evt_valid}, 32'd0);
        chk("post_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("sb_final", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
